qmult_pipe: RTL and testbench
=============================

Name: qmult_pipe

Overview:
- Pipelined, multi-lane successor to the combinational sign-magnitude Q-format multiplier. Operand format is unchanged: MSB is the sign, the low N-1 bits are the magnitude, and Q fractional bits are retained.
- Adds LANES parallel lanes, a valid/ready handshake with stall, selectable truncate or round-half-up, optional saturation, per-result overflow flags and a sticky overflow flag.
- Used in the RCNN datapath (FC/ROI scaling) wherever multiplies need registering.

Parameters:
- N, 32: total word width in bits, sign included.
- Q, 15: number of fractional bits; must satisfy 1 <= Q <= N-2.
- LANES, 4: number of independent multiplier lanes sharing one handshake.
- SAT, 1: 1 = clamp to max magnitude on overflow; 0 = wrap (keep low bits).

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: asynchronous, active-high reset.
- i_valid, in, 1: input beat valid.
- o_ready, out, 1: input beat accepted when i_valid && o_ready.
- i_multiplicand, in, LANES*N: lane k occupies bits [k*N +: N].
- i_multiplier, in, LANES*N: same packing as i_multiplicand.
- i_round, in, 1: 0 = truncate, 1 = round half up on magnitude; travels with the beat.
- o_valid, out, 1: output beat valid.
- i_ready, in, 1: downstream accepts when o_valid && i_ready.
- o_result, out, LANES*N: same packing as the inputs.
- o_ovr, out, LANES: per-lane overflow flag for the current output beat.
- o_ovr_sticky, out, 1: set by any overflow on a beat that is handed off downstream.
- i_ovr_clr, in, 1: synchronous clear of o_ovr_sticky.

Behaviour:
- Reset (asynchronous, active-high):
  - All stage valids, o_valid, o_result, o_ovr and o_ovr_sticky go to 0.
  - o_ready is 1 once reset is released.
  - Beats in flight are dropped.
- Pipeline: three stages, S1 register inputs, S2 multiply, S3 round/saturate/output.
  - Latency is exactly 3 cycles from the accepting edge to o_valid, with no stall.
  - Throughput is 1 beat per cycle.
- Stall:
  - adv = !s3_valid || i_ready; the whole pipe advances when adv is true.
  - o_ready = adv, combinational, with no other logic in that path.
  - When adv = 0, all stage registers hold and o_result/o_ovr stay stable while o_valid = 1.
  - Bubbles are not compacted. Beats are never dropped, duplicated or reordered.
- S1 per lane:
  - sgn = a[N-1] ^ b[N-1].
  - ma = a[N-2:0], mb = b[N-2:0].
  - i_round is registered alongside.
- S2 per lane:
  - p = ma * mb, unsigned, 2N-2 bits.
  - Signed multiply is not used.
- S3 per lane:
  - t = p[N-2+Q:Q].
  - r = i_round ? p[Q-1] : 0.
  - m = t + r, computed N bits wide.
  - ovr = (p[2N-3:N-1+Q] != 0) || m[N-1].
  - If ovr: magnitude = SAT ? all ones (N-1 bits) : m[N-2:0]. Otherwise magnitude = m[N-2:0].
  - Negative zero: if the final magnitude is 0, the sign is forced to 0.
  - o_result lane = {sign, magnitude}; o_ovr[k] = ovr.
- Sticky flag:
  - Sets on any |o_ovr while o_valid && i_ready.
  - Clears on i_ovr_clr.
  - If set and clear occur in the same cycle, set wins.
- Mode changes: i_round changes between beats take effect per beat; no flush is required.
- Reset mid-stream: the pipe empties immediately and the first beat accepted after release is output 3 cycles later.

Decomposition:
- Package qmult_pkg:
  - Field-slice helpers: SIGN_BIT = N-1, MAG_W = N-1, PROD_W = 2N-2.
  - Rounding mode constants RND_TRUNC = 0, RND_HALF_UP = 1.
- Sub-module qmult_lane: combinational S3 round/saturate/negative-zero logic for one lane.
  - Instantiated LANES times in a generate loop.
  - The top holds the pipeline registers and the handshake.

Test Plan (N=32, Q=15, LANES=4, SAT=1 unless noted):
- Basic, all lanes, no stall: lane0 0x0000C000*0x00010000 (1.5*2.0), lane1 0x8000C000*0x00010000, lane2 0x00008000*0x00008000, lane3 0x0*0x80010000 -> 0x00018000, 0x80018000, 0x00008000, 0x00000000; o_valid 3 cycles after accept; o_ovr = 0.
- Overflow: 0x40000000*0x00010000.
  - SAT=1 -> 0x7FFFFFFF, o_ovr[0] = 1, o_ovr_sticky = 1 after handoff.
  - Rerun with SAT=0 -> 0x00000000, o_ovr[0] = 1.
- Rounding: 0x00000003*0x00004000 (1.5 LSB).
  - i_round=0 -> 0x00000001.
  - i_round=1 -> 0x00000002.
  - 0x7FFFFFFF*0x00008000 with i_round=1 -> 0x7FFFFFFF, ovr = 0.
- Negative zero: 0x80000001*0x00004000 with i_round=0 -> 0x00000000; with i_round=1 -> 0x80000001.
- Backpressure: stream 8 beats back-to-back with i_ready low for cycles 4-8.
  - o_ready falls the cycle S3 is full and i_ready is low.
  - All 8 results emerge in order with none lost; o_result stays stable while stalled.
- Sticky and reset:
  - Assert overflow, then i_ovr_clr in the same cycle as a new overflowing handoff -> sticky stays 1.
  - Assert i_rst with 3 beats in flight -> o_valid = 0 immediately, no stale beats after release.

Source files
------------

// File: rtl/qmult_pkg.sv
// Shared field-width helpers and rounding-mode encodings for the sign-magnitude
// Q-format multiplier pipeline.
package qmult_pkg;

  localparam logic RND_TRUNC   = 1'b0;
  localparam logic RND_HALF_UP = 1'b1;

  function automatic int sign_bit(input int n);
    return n - 1;
  endfunction

  function automatic int mag_w(input int n);
    return n - 1;
  endfunction

  function automatic int prod_w(input int n);
    return 2 * n - 2;
  endfunction

  // Product bits from the rounding bit (Q-1) upward; lower bits never affect the result.
  function automatic int kept_w(input int n, input int q);
    return prod_w(n) - q + 1;
  endfunction

endpackage

// File: rtl/qmult_lane.sv
// One lane of the output stage: round, overflow detect, saturate/wrap and
// negative-zero suppression on a registered magnitude product.
module qmult_lane
  import qmult_pkg::*;
#(
  parameter int N   = 32,
  parameter int Q   = 15,
  parameter int SAT = 1
) (
  input  logic                   sgn_i,
  input  logic [kept_w(N,Q)-1:0] prod_i,
  input  logic                   rnd_i,
  output logic [N-1:0]           result_o,
  output logic                   ovr_o
);

  localparam int MAG_W  = mag_w(N);
  localparam int KEEP_W = kept_w(N, Q);

  logic             rnd_bit;
  logic [N-1:0]     m;
  logic [MAG_W-1:0] mag;

  // prod_i[0] is product bit Q-1; prod_i[N-1:1] is the retained field p[N-2+Q:Q].
  always_comb begin
    rnd_bit  = (rnd_i == RND_HALF_UP) ? prod_i[0] : 1'b0;
    m        = {1'b0, prod_i[N-1:1]} + {{MAG_W{1'b0}}, rnd_bit};
    ovr_o    = (|prod_i[KEEP_W-1:N]) || m[N-1];
    mag      = m[MAG_W-1:0];
    if (ovr_o && (SAT != 0)) mag = '1;
    result_o = {(mag != '0) ? sgn_i : 1'b0, mag};
  end

endmodule

// File: rtl/qmult_pipe.sv
// Three-stage, multi-lane sign-magnitude Q-format multiplier with a shared
// valid/ready handshake, per-beat rounding mode and sticky overflow.
module qmult_pipe
  import qmult_pkg::*;
#(
  parameter int N     = 32,
  parameter int Q     = 15,
  parameter int LANES = 4,
  parameter int SAT   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [LANES*N-1:0] i_multiplicand,
  input  logic [LANES*N-1:0] i_multiplier,
  input  logic               i_round,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [LANES*N-1:0] o_result,
  output logic [LANES-1:0]   o_ovr,
  output logic               o_ovr_sticky,
  input  logic               i_ovr_clr
);

  localparam int SIGN_BIT = sign_bit(N);
  localparam int MAG_W    = mag_w(N);
  localparam int PROD_W   = prod_w(N);
  localparam int KEEP_W   = kept_w(N, Q);

  logic              adv;

  logic              s1_valid_q;
  logic              s1_rnd_q;
  logic [LANES-1:0]  s1_sgn_q;
  logic [MAG_W-1:0]  s1_ma_q [LANES];
  logic [MAG_W-1:0]  s1_mb_q [LANES];

  logic [PROD_W-1:0] prod_d  [LANES];

  logic              s2_valid_q;
  logic              s2_rnd_q;
  logic [LANES-1:0]  s2_sgn_q;
  logic [KEEP_W-1:0] s2_prod_q [LANES];

  logic [LANES*N-1:0] lane_res;
  logic [LANES-1:0]   lane_ovr;

  logic               s3_valid_q;
  logic [LANES*N-1:0] s3_result_q;
  logic [LANES-1:0]   s3_ovr_q;

  logic               sticky_d, sticky_q;

  assign adv          = !s3_valid_q || i_ready;
  assign o_ready      = adv;
  assign o_valid      = s3_valid_q;
  assign o_result     = s3_result_q;
  assign o_ovr        = s3_ovr_q;
  assign o_ovr_sticky = sticky_q;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod_d[k] = PROD_W'(s1_ma_q[k]) * PROD_W'(s1_mb_q[k]);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    qmult_lane #(
      .N   (N),
      .Q   (Q),
      .SAT (SAT)
    ) u_lane (
      .sgn_i    (s2_sgn_q[k]),
      .prod_i   (s2_prod_q[k]),
      .rnd_i    (s2_rnd_q),
      .result_o (lane_res[k*N +: N]),
      .ovr_o    (lane_ovr[k])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_rnd_q    <= RND_TRUNC;
      s1_sgn_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_rnd_q    <= RND_TRUNC;
      s2_sgn_q    <= '0;
      s3_valid_q  <= 1'b0;
      s3_result_q <= '0;
      s3_ovr_q    <= '0;
      for (int k = 0; k < LANES; k++) begin
        s1_ma_q[k]   <= '0;
        s1_mb_q[k]   <= '0;
        s2_prod_q[k] <= '0;
      end
    end else if (adv) begin
      s1_valid_q  <= i_valid;
      s1_rnd_q    <= i_round;
      s2_valid_q  <= s1_valid_q;
      s2_rnd_q    <= s1_rnd_q;
      s2_sgn_q    <= s1_sgn_q;
      s3_valid_q  <= s2_valid_q;
      s3_result_q <= lane_res;
      s3_ovr_q    <= lane_ovr;
      for (int k = 0; k < LANES; k++) begin
        s1_sgn_q[k]  <= i_multiplicand[k*N + SIGN_BIT] ^ i_multiplier[k*N + SIGN_BIT];
        s1_ma_q[k]   <= i_multiplicand[k*N +: MAG_W];
        s1_mb_q[k]   <= i_multiplier[k*N +: MAG_W];
        // Bits below Q-1 cannot influence rounding or the result, so they are not kept.
        s2_prod_q[k] <= KEEP_W'(prod_d[k] >> (Q - 1));
      end
    end
  end

  // A set from a handed-off overflowing beat wins over a same-cycle clear.
  always_comb begin
    sticky_d = sticky_q;
    if (i_ovr_clr) sticky_d = 1'b0;
    if (s3_valid_q && i_ready && (|s3_ovr_q)) sticky_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

endmodule

// File: tb/tb_qmult_pipe.sv
// Directed-vector bench for qmult_pipe; a SAT=1 and a SAT=0 instance share stimulus.
module tb_qmult_pipe;

  localparam int N     = 32;
  localparam int Q     = 15;
  localparam int LANES = 4;
  localparam int W     = LANES * N;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic [W-1:0] i_multiplicand;
  logic [W-1:0] i_multiplier;
  logic         i_round;
  logic         i_ready;
  logic         i_ovr_clr;

  logic         o_ready,  o_valid,  o_ovr_sticky;
  logic [W-1:0] o_result;
  logic [3:0]   o_ovr;
  logic         w_ready,  w_valid,  w_ovr_sticky;
  logic [W-1:0] w_result;
  logic [3:0]   w_ovr;

  int vecs = 0;
  int errs = 0;

  always #5 i_clk = ~i_clk;

  qmult_pipe #(.N(N), .Q(Q), .LANES(LANES), .SAT(1)) u_sat (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_multiplicand(i_multiplicand), .i_multiplier(i_multiplier), .i_round(i_round),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_ovr(o_ovr),
    .o_ovr_sticky(o_ovr_sticky), .i_ovr_clr(i_ovr_clr)
  );

  qmult_pipe #(.N(N), .Q(Q), .LANES(LANES), .SAT(0)) u_wrap (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(w_ready),
    .i_multiplicand(i_multiplicand), .i_multiplier(i_multiplier), .i_round(i_round),
    .o_valid(w_valid), .i_ready(i_ready), .o_result(w_result), .o_ovr(w_ovr),
    .o_ovr_sticky(w_ovr_sticky), .i_ovr_clr(i_ovr_clr)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [W-1:0] bp_a(input int j);
    return {32'(j), 32'(j), 32'(j), 32'((j + 1) << 15)};
  endfunction

  function automatic logic [W-1:0] bp_b();
    return {32'h00008000, 32'h00008000, 32'h00008000, 32'h00010000};
  endfunction

  function automatic logic [W-1:0] bp_exp(input int j);
    return {32'(j), 32'(j), 32'(j), 32'((j + 1) << 16)};
  endfunction

  // Single beat into an empty pipe with i_ready high; i_round is flipped after
  // acceptance so a result that ignores the registered mode is caught.
  task automatic run_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic rnd,
                          output logic [W-1:0] rs, output logic [3:0] os,
                          output logic [W-1:0] rw, output logic [3:0] ow);
    i_multiplicand = a;
    i_multiplier   = b;
    i_round        = rnd;
    i_valid        = 1'b1;
    #1;
    check("beat_ready", o_ready, 1'b1);
    tick();
    i_valid        = 1'b0;
    i_round        = ~rnd;
    i_multiplicand = '1;
    i_multiplier   = '1;
    tick();
    check("lat_early", o_valid, 1'b0);
    tick();
    check("lat_sat", o_valid, 1'b1);
    check("lat_wrap", w_valid, 1'b1);
    rs = o_result;
    os = o_ovr;
    rw = w_result;
    ow = w_ovr;
    tick();
    i_round = 1'b0;
  endtask

  logic [W-1:0] rs, rw;
  logic [3:0]   os, ow;
  logic [W-1:0] ovf_a, ovf_b, rnd_a, rnd_b, basic_a, basic_b, basic_exp;

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_round = 1'b0; i_ready = 1'b1; i_ovr_clr = 1'b0;
    i_multiplicand = '0; i_multiplier = '0;
    basic_a   = {32'h00000000, 32'h00008000, 32'h8000C000, 32'h0000C000};
    basic_b   = {32'h80010000, 32'h00008000, 32'h00010000, 32'h00010000};
    basic_exp = {32'h00000000, 32'h00008000, 32'h80018000, 32'h00018000};
    ovf_a     = {96'h0, 32'h40000000};
    ovf_b     = {96'h0, 32'h00010000};
    rnd_a     = {32'h3FFFC000, 32'h80000001, 32'h7FFFFFFF, 32'h00000003};
    rnd_b     = {32'h00010001, 32'h00004000, 32'h00008000, 32'h00004000};

    #12;
    check("rst_valid", o_valid, 1'b0);
    check("rst_result", o_result, '0);
    check("rst_ovr", o_ovr, 4'b0);
    check("rst_sticky", o_ovr_sticky, 1'b0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    #1;
    check("rst_ready", o_ready, 1'b1);

    run_beat(basic_a, basic_b, 1'b0, rs, os, rw, ow);
    check("basic_res", rs, basic_exp);
    check("basic_ovr", os, 4'b0000);
    check("basic_res_wrap", rw, basic_exp);

    run_beat(ovf_a, ovf_b, 1'b0, rs, os, rw, ow);
    check("ovf_sat_res", rs, {96'h0, 32'h7FFFFFFF});
    check("ovf_sat_flag", os, 4'b0001);
    check("ovf_wrap_res", rw, '0);
    check("ovf_wrap_flag", ow, 4'b0001);
    check("ovf_sticky", o_ovr_sticky, 1'b1);

    i_ovr_clr = 1'b1;
    tick();
    i_ovr_clr = 1'b0;
    check("sticky_clr", o_ovr_sticky, 1'b0);

    run_beat(rnd_a, rnd_b, 1'b0, rs, os, rw, ow);
    check("trunc_res", rs, {32'h7FFFFFFF, 32'h00000000, 32'h7FFFFFFF, 32'h00000001});
    check("trunc_ovr", os, 4'b0000);
    check("trunc_res_wrap", rw, {32'h7FFFFFFF, 32'h00000000, 32'h7FFFFFFF, 32'h00000001});
    check("trunc_sticky", o_ovr_sticky, 1'b0);

    run_beat(rnd_a, rnd_b, 1'b1, rs, os, rw, ow);
    check("round_res", rs, {32'h7FFFFFFF, 32'h80000001, 32'h7FFFFFFF, 32'h00000002});
    check("round_ovr", os, 4'b1000);
    check("round_res_wrap", rw, {32'h00000000, 32'h80000001, 32'h7FFFFFFF, 32'h00000002});
    check("round_ovr_wrap", ow, 4'b1000);

    // Clear held through an overflowing handoff: set must win.
    i_ovr_clr = 1'b1;
    tick();
    check("sticky_clr2", o_ovr_sticky, 1'b0);
    run_beat(ovf_a, ovf_b, 1'b0, rs, os, rw, ow);
    check("sticky_set_wins", o_ovr_sticky, 1'b1);
    i_ovr_clr = 1'b0;
    tick();
    check("sticky_holds", o_ovr_sticky, 1'b1);

    begin : backpressure
      int           sent = 0;
      int           recv = 0;
      logic         held_v = 1'b0;
      logic [W-1:0] held = '0;
      for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
        i_ready = !(cyc >= 4 && cyc <= 8);
        i_valid = (sent < 8);
        if (sent < 8) begin
          i_multiplicand = bp_a(sent);
          i_multiplier   = bp_b();
        end
        #1;
        if (cyc == 4) check("bp_ready_low", o_ready, 1'b0);
        if (held_v && o_valid) check("bp_hold", o_result, held);
        held_v = o_valid && !i_ready;
        held   = o_result;
        if (o_valid && i_ready) begin
          check("bp_data", o_result, bp_exp(recv));
          recv++;
        end
        if (i_valid && o_ready) sent++;
        @(posedge i_clk); #1;
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      check("bp_count", recv, 8);
    end

    begin : reset_mid
      logic stale = 1'b0;
      for (int j = 0; j < 3; j++) begin
        i_multiplicand = bp_a(j);
        i_multiplier   = bp_b();
        i_valid        = 1'b1;
        tick();
      end
      i_valid = 1'b0;
      check("rst_mid_pre", o_valid, 1'b1);
      i_rst = 1'b1;
      #1;
      check("rst_mid_valid", o_valid, 1'b0);
      check("rst_mid_result", o_result, '0);
      check("rst_mid_sticky", o_ovr_sticky, 1'b0);
      tick();
      i_rst = 1'b0;
      for (int j = 0; j < 6; j++) begin
        tick();
        if (o_valid || w_valid) stale = 1'b1;
      end
      check("rst_stale", stale, 1'b0);
      run_beat(basic_a, basic_b, 1'b0, rs, os, rw, ow);
      check("post_rst_res", rs, basic_exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
